// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary add/subtract sequencer: state codes and operand field widths.
// Optional build macro used by the top level: ROTARY_SEQ_AUTOCLEAR_EN.
package rotary_pkg;

    localparam int DEFAULT_WIDTH = 7;
    localparam int LO_W          = 4;
    localparam int HI_W_DEFAULT  = DEFAULT_WIDTH - LO_W;

    // The high field takes whatever remains of the operand above the 4-bit low field.
    function automatic int hi_width(input int width);
        return width - LO_W;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_A_HI = 3'd1,
        ST_LOAD_A_LO = 3'd2,
        ST_LOAD_B_HI = 3'd3,
        ST_LOAD_B_LO = 3'd4,
        ST_LOAD_CIN  = 3'd5,
        ST_COMPUTE   = 3'd6,
        ST_SHOW      = 3'd7
    } state_t;

endpackage

// File: rtl/rotary_add_sequencer_if.sv
// Bus between the encoder front end / LED bank (master) and the add sequencer (slave).
interface rotary_add_sequencer_if #(
    parameter int WIDTH = rotary_pkg::DEFAULT_WIDTH
);

    logic             step_up;
    logic             step_down;
    logic [3:0]       holder;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             cin;
    logic [WIDTH:0]   result;
    logic             result_valid;
    logic             busy;
    logic [7:0]       led;

    modport master (
        output step_up, step_down, holder,
        input  num1, num2, cin, result, result_valid, busy, led
    );

    modport slave (
        input  step_up, step_down, holder,
        output num1, num2, cin, result, result_valid, busy, led
    );

endinterface

// File: rtl/rca_addsub.sv
// WIDTH-bit ripple-carry adder/subtractor; sub=1 inverts b and injects a carry of 1.
module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module rca_addsub
    import rotary_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_eff;

    assign carry[0] = sub;
    assign b_eff    = b ^ {WIDTH{sub}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rca_fa_cell u_fa (
            .a  (a[i]),
            .b  (b_eff[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Final carry out doubles as the "no borrow" flag when subtracting.
    assign sum[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/rotary_add_sequencer.sv
// Operand-entry and compute sequencer for the rotary add/subtract datapath.
// Define ROTARY_SEQ_AUTOCLEAR_EN to clear operands and mode when a new entry sequence starts.
module rotary_add_sequencer
    import rotary_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    rotary_add_sequencer_if.slave bus
);

    localparam int HI_W = hi_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] num1_q;
    logic [WIDTH-1:0] num2_q;
    logic             cin_q;
    logic [WIDTH:0]   result_q;
    logic             result_valid_q;
    logic             busy_q;
    logic [7:0]       led_q;
    logic [WIDTH:0]   sum;
    logic [7:0]       led_result;
    logic             up_only;
    logic             down_only;

    assign up_only   = bus.step_up & ~bus.step_down;
    assign down_only = bus.step_down & ~bus.step_up;

    rca_addsub #(.WIDTH(WIDTH)) u_adder (
        .a   (num1_q),
        .b   (num2_q),
        .sub (cin_q),
        .sum (sum)
    );

    // Result zero-extended (or truncated for the 8-bit case) onto the 8 LEDs.
    if (WIDTH + 1 >= 8) begin : g_led_trunc
        assign led_result = result_q[7:0];
    end else begin : g_led_ext
        assign led_result = {{(7 - WIDTH){1'b0}}, result_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            num1_q         <= '0;
            num2_q         <= '0;
            cin_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            led_q          <= 8'h00;
        end else begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            if (state == ST_COMPUTE || state == ST_SHOW)
                led_q <= led_result;
            else
                led_q <= {state, 1'b0, bus.holder};

            if (up_only) begin
                unique case (state)
                    ST_IDLE: begin
                        state <= ST_LOAD_A_HI;
`ifdef ROTARY_SEQ_AUTOCLEAR_EN
                        num1_q <= '0;
                        num2_q <= '0;
                        cin_q  <= 1'b0;
`endif
                    end
                    ST_LOAD_A_HI: begin
                        num1_q[WIDTH-1:LO_W] <= bus.holder[HI_W-1:0];
                        state                <= ST_LOAD_A_LO;
                    end
                    ST_LOAD_A_LO: begin
                        num1_q[LO_W-1:0] <= bus.holder;
                        state            <= ST_LOAD_B_HI;
                    end
                    ST_LOAD_B_HI: begin
                        num2_q[WIDTH-1:LO_W] <= bus.holder[HI_W-1:0];
                        state                <= ST_LOAD_B_LO;
                    end
                    ST_LOAD_B_LO: begin
                        num2_q[LO_W-1:0] <= bus.holder;
                        state            <= ST_LOAD_CIN;
                    end
                    ST_LOAD_CIN: begin
                        cin_q  <= bus.holder[0];
                        busy_q <= 1'b1;
                        state  <= ST_COMPUTE;
                    end
                    ST_SHOW: begin
                        state <= ST_LOAD_A_HI;
`ifdef ROTARY_SEQ_AUTOCLEAR_EN
                        num1_q <= '0;
                        num2_q <= '0;
                        cin_q  <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end else if (down_only) begin
                unique case (state)
                    ST_LOAD_A_HI: state <= ST_IDLE;
                    ST_LOAD_A_LO: state <= ST_LOAD_A_HI;
                    ST_LOAD_B_HI: state <= ST_LOAD_A_LO;
                    ST_LOAD_B_LO: state <= ST_LOAD_B_HI;
                    ST_LOAD_CIN:  state <= ST_LOAD_B_LO;
                    ST_SHOW:      state <= ST_LOAD_CIN;
                    default: ;
                endcase
            end

            // COMPUTE is a fixed single cycle regardless of step inputs.
            if (state == ST_COMPUTE) begin
                result_q       <= sum;
                result_valid_q <= 1'b1;
                state          <= ST_SHOW;
            end
        end
    end

    assign bus.num1         = num1_q;
    assign bus.num2         = num2_q;
    assign bus.cin          = cin_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.led          = led_q;

endmodule

// File: tb/tb_rotary_add_sequencer.sv
// Scoreboard bench for rotary_add_sequencer; honours ROTARY_SEQ_AUTOCLEAR_EN when defined.
module tb_rotary_add_sequencer;

    localparam int W = 7;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   cycles;
    logic [W:0] exp_q[$];

    rotary_add_sequencer_if #(.WIDTH(W)) bus ();

    rotary_add_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One step pulse spanning exactly one rising edge; returns at the following falling edge.
    task automatic applyStimulus(input logic up, input logic down, input logic [3:0] hold);
        @(negedge clk);
        bus.step_up   = up;
        bus.step_down = down;
        bus.holder    = hold;
        @(negedge clk);
        bus.step_up   = 1'b0;
        bus.step_down = 1'b0;
    endtask

    function automatic logic [W:0] expResult(input int a, input int b, input logic sub);
        int r;
        r = sub ? (a - b + (1 << W)) : (a + b);
        return r[W:0];
    endfunction

    // Scoreboard: every result_valid pulse must match the oldest pending expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.result_valid === 1'b1) begin
                if (exp_q.size() == 0)
                    checkOutput("unexpected_valid", 32'(bus.result_valid), 32'd0);
                else
                    checkOutput("result", 32'(bus.result), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        cycles = 0;
        forever begin
            @(posedge clk);
            cycles++;
            if (cycles > 5000) begin
                $display("[TB] FAIL timeout: got %0d cycles expected under 5000", cycles);
                $fatal(1, "[TB] timeout");
            end
        end
    end

    initial begin
        logic [31:0] num1_keep;
        logic [31:0] num2_keep;
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.step_up   = 1'b0;
        bus.step_down = 1'b0;
        bus.holder    = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_num1", 32'(bus.num1), 32'h0);
        checkOutput("rst_num2", 32'(bus.num2), 32'h0);
        checkOutput("rst_cin", 32'(bus.cin), 32'h0);
        checkOutput("rst_result", 32'(bus.result), 32'h0);
        checkOutput("rst_valid", 32'(bus.result_valid), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_led", 32'(bus.led), 32'h0);
        reset = 1'b0;

        // First add: 0x35 + 0x29
        applyStimulus(1, 0, 4'd3);
        applyStimulus(1, 0, 4'd3);
        applyStimulus(1, 0, 4'd5);
        applyStimulus(1, 0, 4'd2);
        applyStimulus(1, 0, 4'd9);
        exp_q.push_back(expResult(32'h35, 32'h29, 1'b0));
        applyStimulus(1, 0, 4'd0);
        checkOutput("busy_compute", 32'(bus.busy), 32'h1);
        checkOutput("valid_early", 32'(bus.result_valid), 32'h0);
        checkOutput("add_num1", 32'(bus.num1), 32'h35);
        checkOutput("add_num2", 32'(bus.num2), 32'h29);
        checkOutput("add_cin", 32'(bus.cin), 32'h0);
        @(negedge clk);
        checkOutput("valid_pulse", 32'(bus.result_valid), 32'h1);
        checkOutput("busy_after", 32'(bus.busy), 32'h0);
        @(negedge clk);
        checkOutput("valid_single", 32'(bus.result_valid), 32'h0);
        checkOutput("add_led", 32'(bus.led), 32'h5E);

        // Flip mode from SHOW and recompute as a subtraction
        applyStimulus(0, 1, 4'd1);
        exp_q.push_back(expResult(32'h35, 32'h29, 1'b1));
        applyStimulus(1, 0, 4'd1);
        checkOutput("sub_cin", 32'(bus.cin), 32'h1);
        repeat (3) @(negedge clk);
        checkOutput("sub_num1", 32'(bus.num1), 32'h35);
        checkOutput("sub_num2", 32'(bus.num2), 32'h29);
        checkOutput("sub_led", 32'(bus.led), 32'(expResult(32'h35, 32'h29, 1'b1)));

        // Leave SHOW via step_up: operands cleared only in the autoclear build
        applyStimulus(1, 0, 4'd4);
`ifdef ROTARY_SEQ_AUTOCLEAR_EN
        num1_keep = 32'h00;
        num2_keep = 32'h00;
        checkOutput("leave_cin", 32'(bus.cin), 32'h0);
`else
        num1_keep = 32'h35;
        num2_keep = 32'h29;
        checkOutput("leave_cin", 32'(bus.cin), 32'h1);
`endif
        checkOutput("leave_num1", 32'(bus.num1), num1_keep);
        applyStimulus(1, 0, 4'd4);
        applyStimulus(1, 0, 4'd6);
        checkOutput("new_num1", 32'(bus.num1), 32'h46);

        // Simultaneous steps in LOAD_B_HI are ignored
        applyStimulus(1, 1, 4'd7);
        @(negedge clk);
        checkOutput("both_num2", 32'(bus.num2), num2_keep);
        checkOutput("both_state", 32'(bus.led[7:5]), 32'd3);

        // High field keeps only holder[2:0]
        applyStimulus(1, 0, 4'hF);
        applyStimulus(1, 0, 4'hA);
        checkOutput("b_trunc", 32'(bus.num2), 32'h7A);
        exp_q.push_back(expResult(32'h46, 32'h7A, 1'b0));
        applyStimulus(1, 0, 4'd0);
        repeat (3) @(negedge clk);
        checkOutput("add2_led", 32'(bus.led), 32'hC0);

        // Reset during COMPUTE aborts with no result_valid
        applyStimulus(0, 1, 4'd1);
        applyStimulus(1, 0, 4'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_valid", 32'(bus.result_valid), 32'h0);
        checkOutput("abort_result", 32'(bus.result), 32'h0);
        checkOutput("abort_num1", 32'(bus.num1), 32'h0);
        checkOutput("abort_busy0", 32'(bus.busy), 32'h0);
        checkOutput("abort_led", 32'(bus.led), 32'h0);
        @(negedge clk);
        checkOutput("abort_idle", 32'(bus.led[7:5]), 32'd0);

        // step_down in IDLE is ignored; step_down from LOAD_A_HI returns to IDLE
        applyStimulus(0, 1, 4'd2);
        @(negedge clk);
        checkOutput("idle_down", 32'(bus.led), 32'h02);
        applyStimulus(1, 0, 4'd2);
        @(negedge clk);
        checkOutput("a_hi_state", 32'(bus.led[7:5]), 32'd1);
        applyStimulus(0, 1, 4'd2);
        @(negedge clk);
        checkOutput("back_idle", 32'(bus.led[7:5]), 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
